// File: rtl/convolution_2d_pkg.sv
// Shared types and helpers for the convolution datapath stages.
// Saturation bounds are returned in a wide signed container so callers can compare any accumulator width.
package convolution_2d_pkg;

    localparam int unsigned DEFAULT_TAP_WIDTH = 16;
    localparam int unsigned SAT_W             = 128;

    function automatic logic signed [SAT_W-1:0] sat_max(input int unsigned w);
        logic signed [SAT_W-1:0] r;
        r = SAT_W'(1);
        r = (r << (w - 1)) - SAT_W'(1);
        return r;
    endfunction

    function automatic logic signed [SAT_W-1:0] sat_min(input int unsigned w);
        logic signed [SAT_W-1:0] r;
        r = SAT_W'(1);
        r = -(r << (w - 1));
        return r;
    endfunction

endpackage

// File: rtl/convolution_2d_saturate.sv
// Combinational signed saturation from a wide sum down to DATA_WIDTH with an overflow flag.
// Shared with the pooling stage.
module convolution_2d_saturate
    import convolution_2d_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ACC_WIDTH  = 48
) (
    input  logic signed [ACC_WIDTH:0]    sum,
    output logic        [DATA_WIDTH-1:0] data_c,
    output logic                         overflow_c
);

    logic signed [SAT_W-1:0] sum_ext;

    assign sum_ext = SAT_W'(sum);

    always_comb begin
        data_c     = sum[DATA_WIDTH-1:0];
        overflow_c = 1'b0;
        if (sum_ext > sat_max(DATA_WIDTH)) begin
            data_c     = DATA_WIDTH'(sat_max(DATA_WIDTH));
            overflow_c = 1'b1;
        end else if (sum_ext < sat_min(DATA_WIDTH)) begin
            data_c     = DATA_WIDTH'(sat_min(DATA_WIDTH));
            overflow_c = 1'b1;
        end
    end

endmodule

// File: rtl/convolution_2d_accumulator.sv
// Sums CFG_TAPS signed products per output pixel, adds bias, saturates, and emits
// the result through a single-entry ready/valid output register.
module convolution_2d_accumulator
    import convolution_2d_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned USER_WIDTH = DATA_WIDTH / 8,
    parameter int unsigned TAP_WIDTH  = DEFAULT_TAP_WIDTH,
    parameter int unsigned ACC_WIDTH  = DATA_WIDTH + TAP_WIDTH
) (
    input  logic                  CLK,
    input  logic                  RESET_N,
    input  logic [TAP_WIDTH-1:0]  CFG_TAPS,
    input  logic [DATA_WIDTH-1:0] BIAS,
    output logic                  IN_READY,
    input  logic                  IN_VALID,
    input  logic [DATA_WIDTH-1:0] IN_DATA,
    input  logic [USER_WIDTH-1:0] IN_USER,
    input  logic                  IN_LAST,
    input  logic                  OUT_READY,
    output logic                  OUT_VALID,
    output logic [DATA_WIDTH-1:0] OUT_DATA,
    output logic [USER_WIDTH-1:0] OUT_USER,
    output logic                  OUT_LAST,
    output logic                  OUT_OVERFLOW,
    output logic                  ERR_LAST
);

    localparam int unsigned SUM_WIDTH = ACC_WIDTH + 1;

    logic        [TAP_WIDTH-1:0]  cnt;
    logic signed [ACC_WIDTH-1:0]  acc;
    logic        [TAP_WIDTH-1:0]  taps_c;
    logic                         final_tap_c;
    logic                         in_fire_c;
    logic signed [SUM_WIDTH-1:0]  sum_c;
    logic        [DATA_WIDTH-1:0] sat_data_c;
    logic                         sat_ovf_c;

    // A zero tap count degenerates to one product per output.
    assign taps_c      = (CFG_TAPS == '0) ? TAP_WIDTH'(1) : CFG_TAPS;
    assign final_tap_c = (cnt == taps_c - TAP_WIDTH'(1));
    assign IN_READY    = ~final_tap_c | ~OUT_VALID | OUT_READY;
    assign in_fire_c   = IN_VALID & IN_READY;

    assign sum_c = SUM_WIDTH'(acc) + SUM_WIDTH'($signed(IN_DATA)) + SUM_WIDTH'($signed(BIAS));

    convolution_2d_saturate #(
        .DATA_WIDTH (DATA_WIDTH),
        .ACC_WIDTH  (ACC_WIDTH)
    ) u_saturate (
        .sum        (sum_c),
        .data_c     (sat_data_c),
        .overflow_c (sat_ovf_c)
    );

    // Drain clears OUT_VALID first; a same-cycle final tap then reloads it without a bubble.
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            cnt          <= '0;
            acc          <= '0;
            OUT_VALID    <= 1'b0;
            OUT_DATA     <= '0;
            OUT_USER     <= '0;
            OUT_LAST     <= 1'b0;
            OUT_OVERFLOW <= 1'b0;
            ERR_LAST     <= 1'b0;
        end else begin
            if (OUT_VALID && OUT_READY) begin
                OUT_VALID <= 1'b0;
            end
            if (in_fire_c) begin
                if (final_tap_c) begin
                    OUT_DATA     <= sat_data_c;
                    OUT_OVERFLOW <= sat_ovf_c;
                    OUT_USER     <= IN_USER;
                    OUT_LAST     <= IN_LAST;
                    OUT_VALID    <= 1'b1;
                    acc          <= '0;
                    cnt          <= '0;
                end else begin
                    acc <= acc + ACC_WIDTH'($signed(IN_DATA));
                    cnt <= cnt + TAP_WIDTH'(1);
                    if (IN_LAST) begin
                        ERR_LAST <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_convolution_2d_accumulator.sv
// Directed self-checking bench for convolution_2d_accumulator (default 32-bit configuration).
module tb_convolution_2d_accumulator;

    logic        CLK = 1'b0;
    logic        RESET_N;
    logic [15:0] CFG_TAPS;
    logic [31:0] BIAS;
    logic        IN_READY;
    logic        IN_VALID;
    logic [31:0] IN_DATA;
    logic [3:0]  IN_USER;
    logic        IN_LAST;
    logic        OUT_READY;
    logic        OUT_VALID;
    logic [31:0] OUT_DATA;
    logic [3:0]  OUT_USER;
    logic        OUT_LAST;
    logic        OUT_OVERFLOW;
    logic        ERR_LAST;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] beats[$];

    convolution_2d_accumulator dut (
        .CLK          (CLK),
        .RESET_N      (RESET_N),
        .CFG_TAPS     (CFG_TAPS),
        .BIAS         (BIAS),
        .IN_READY     (IN_READY),
        .IN_VALID     (IN_VALID),
        .IN_DATA      (IN_DATA),
        .IN_USER      (IN_USER),
        .IN_LAST      (IN_LAST),
        .OUT_READY    (OUT_READY),
        .OUT_VALID    (OUT_VALID),
        .OUT_DATA     (OUT_DATA),
        .OUT_USER     (OUT_USER),
        .OUT_LAST     (OUT_LAST),
        .OUT_OVERFLOW (OUT_OVERFLOW),
        .ERR_LAST     (ERR_LAST)
    );

    always #5 CLK = ~CLK;

    // Inputs only change just after posedge, so negedge sees the values the next edge will use.
    always @(negedge CLK) begin
        if (OUT_VALID && OUT_READY) beats.push_back(OUT_DATA);
    end

    task automatic send_tap(input logic [31:0] d, input logic [3:0] u, input logic l);
        bit done;
        done     = 1'b0;
        IN_VALID = 1'b1;
        IN_DATA  = d;
        IN_USER  = u;
        IN_LAST  = l;
        for (int k = 0; k < 16 && !done; k++) begin
            #1;
            done = IN_READY;
            @(posedge CLK);
            #1;
        end
        IN_VALID = 1'b0;
        IN_LAST  = 1'b0;
        n_checks++;
        if (!done) begin
            n_fail++;
            $display("FAIL send_tap_timeout: product %h never accepted, required handshake within 16 cycles", d);
        end
    endtask

    task automatic test_reset();
        if (OUT_VALID !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b required 0", OUT_VALID); end
        if (OUT_DATA !== 32'h0) begin n_fail++; $display("FAIL reset_out_data: got %h required 0", OUT_DATA); end
        if (OUT_OVERFLOW !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b required 0", OUT_OVERFLOW); end
        if (ERR_LAST !== 1'b0) begin n_fail++; $display("FAIL reset_err_last: got %b required 0", ERR_LAST); end
        if (IN_READY !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b required 1", IN_READY); end
        n_checks += 5;
    endtask

    task automatic test_basic_sum();
        CFG_TAPS = 16'd3; BIAS = 32'd10; OUT_READY = 1'b1;
        send_tap(32'd1, 4'h0, 1'b0);
        send_tap(32'd2, 4'h0, 1'b0);
        n_checks++;
        if (OUT_VALID !== 1'b0) begin n_fail++; $display("FAIL basic_early_valid: got %b required 0", OUT_VALID); end
        send_tap(32'd3, 4'h0, 1'b0);
        n_checks += 3;
        if (OUT_VALID !== 1'b1) begin n_fail++; $display("FAIL basic_valid: got %b required 1", OUT_VALID); end
        if (OUT_DATA !== 32'd16) begin n_fail++; $display("FAIL basic_data: got %0d required 16", OUT_DATA); end
        if (OUT_OVERFLOW !== 1'b0) begin n_fail++; $display("FAIL basic_overflow: got %b required 0", OUT_OVERFLOW); end
        @(posedge CLK); #1;
        n_checks++;
        if (OUT_VALID !== 1'b0) begin n_fail++; $display("FAIL basic_drain: got %b required 0", OUT_VALID); end
    endtask

    task automatic test_saturate();
        CFG_TAPS = 16'd2; BIAS = 32'd0; OUT_READY = 1'b1;
        send_tap(32'h7FFF_FFFF, 4'h0, 1'b0);
        send_tap(32'h0000_0001, 4'h0, 1'b0);
        n_checks += 2;
        if (OUT_DATA !== 32'h7FFF_FFFF) begin n_fail++; $display("FAIL sat_pos_data: got %h required 7fffffff", OUT_DATA); end
        if (OUT_OVERFLOW !== 1'b1) begin n_fail++; $display("FAIL sat_pos_ovf: got %b required 1", OUT_OVERFLOW); end
        send_tap(32'h8000_0000, 4'h0, 1'b0);
        send_tap(32'hFFFF_FFFF, 4'h0, 1'b0);
        n_checks += 2;
        if (OUT_DATA !== 32'h8000_0000) begin n_fail++; $display("FAIL sat_neg_data: got %h required 80000000", OUT_DATA); end
        if (OUT_OVERFLOW !== 1'b1) begin n_fail++; $display("FAIL sat_neg_ovf: got %b required 1", OUT_OVERFLOW); end
    endtask

    task automatic test_taps_zero();
        CFG_TAPS = 16'd0; BIAS = 32'd1; OUT_READY = 1'b1;
        send_tap(32'd5, 4'h0, 1'b0);
        n_checks += 3;
        if (OUT_VALID !== 1'b1) begin n_fail++; $display("FAIL taps0_valid1: got %b required 1", OUT_VALID); end
        if (OUT_DATA !== 32'd6) begin n_fail++; $display("FAIL taps0_data1: got %0d required 6", $signed(OUT_DATA)); end
        if (IN_READY !== 1'b1) begin n_fail++; $display("FAIL taps0_ready1: got %b required 1", IN_READY); end
        send_tap(32'hFFFF_FFF9, 4'h0, 1'b0);
        n_checks += 4;
        if (OUT_VALID !== 1'b1) begin n_fail++; $display("FAIL taps0_valid2: got %b required 1", OUT_VALID); end
        if (OUT_DATA !== 32'hFFFF_FFFA) begin n_fail++; $display("FAIL taps0_data2: got %0d required -6", $signed(OUT_DATA)); end
        if (OUT_OVERFLOW !== 1'b0) begin n_fail++; $display("FAIL taps0_ovf: got %b required 0", OUT_OVERFLOW); end
        if (IN_READY !== 1'b1) begin n_fail++; $display("FAIL taps0_ready2: got %b required 1", IN_READY); end
        @(posedge CLK); #1;
    endtask

    task automatic test_back_to_back();
        CFG_TAPS = 16'd2; BIAS = 32'd0; OUT_READY = 1'b0;
        beats.delete();
        send_tap(32'd1, 4'h0, 1'b0);
        send_tap(32'd2, 4'h0, 1'b0);
        n_checks += 3;
        if (OUT_VALID !== 1'b1) begin n_fail++; $display("FAIL bp_valid: got %b required 1", OUT_VALID); end
        if (OUT_DATA !== 32'd3) begin n_fail++; $display("FAIL bp_first: got %0d required 3", OUT_DATA); end
        if (IN_READY !== 1'b1) begin n_fail++; $display("FAIL bp_ready_nonfinal: got %b required 1", IN_READY); end
        send_tap(32'd3, 4'h0, 1'b0);
        n_checks++;
        if (IN_READY !== 1'b0) begin n_fail++; $display("FAIL bp_ready_final: got %b required 0", IN_READY); end
        IN_VALID = 1'b1; IN_DATA = 32'd4;
        for (int i = 0; i < 3; i++) begin
            @(posedge CLK); #1;
            n_checks += 2;
            if (OUT_DATA !== 32'd3) begin n_fail++; $display("FAIL bp_hold_data: cycle %0d got %0d required 3", i, OUT_DATA); end
            if (IN_READY !== 1'b0) begin n_fail++; $display("FAIL bp_hold_ready: cycle %0d got %b required 0", i, IN_READY); end
        end
        OUT_READY = 1'b1;
        #1;
        n_checks++;
        if (IN_READY !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready: got %b required 1", IN_READY); end
        @(posedge CLK); #1;
        IN_VALID = 1'b0;
        n_checks += 2;
        if (OUT_VALID !== 1'b1) begin n_fail++; $display("FAIL bp_nobubble_valid: got %b required 1", OUT_VALID); end
        if (OUT_DATA !== 32'd7) begin n_fail++; $display("FAIL bp_second: got %0d required 7", OUT_DATA); end
        send_tap(32'd5, 4'h0, 1'b0);
        send_tap(32'd6, 4'h0, 1'b0);
        @(posedge CLK); #1;
        n_checks += 4;
        if (beats.size() !== 3) begin
            n_fail++; $display("FAIL bp_beat_count: got %0d required 3", beats.size());
        end else begin
            if (beats[0] !== 32'd3) begin n_fail++; $display("FAIL bp_order0: got %0d required 3", beats[0]); end
            if (beats[1] !== 32'd7) begin n_fail++; $display("FAIL bp_order1: got %0d required 7", beats[1]); end
            if (beats[2] !== 32'd11) begin n_fail++; $display("FAIL bp_order2: got %0d required 11", beats[2]); end
        end
    endtask

    task automatic test_last();
        CFG_TAPS = 16'd3; BIAS = 32'd0; OUT_READY = 1'b1;
        send_tap(32'd1, 4'h1, 1'b1);
        send_tap(32'd1, 4'h2, 1'b0);
        send_tap(32'd1, 4'hA, 1'b0);
        n_checks += 4;
        if (ERR_LAST !== 1'b1) begin n_fail++; $display("FAIL last_err: got %b required 1", ERR_LAST); end
        if (OUT_LAST !== 1'b0) begin n_fail++; $display("FAIL last_ignored: got %b required 0", OUT_LAST); end
        if (OUT_USER !== 4'hA) begin n_fail++; $display("FAIL last_user1: got %h required a", OUT_USER); end
        if (OUT_DATA !== 32'd3) begin n_fail++; $display("FAIL last_data1: got %0d required 3", OUT_DATA); end
        send_tap(32'd2, 4'h3, 1'b0);
        send_tap(32'd2, 4'h4, 1'b0);
        send_tap(32'd2, 4'h5, 1'b1);
        n_checks += 4;
        if (OUT_LAST !== 1'b1) begin n_fail++; $display("FAIL last_final: got %b required 1", OUT_LAST); end
        if (OUT_USER !== 4'h5) begin n_fail++; $display("FAIL last_user2: got %h required 5", OUT_USER); end
        if (OUT_DATA !== 32'd6) begin n_fail++; $display("FAIL last_data2: got %0d required 6", OUT_DATA); end
        if (ERR_LAST !== 1'b1) begin n_fail++; $display("FAIL last_sticky: got %b required 1", ERR_LAST); end
    endtask

    task automatic test_reset_mid();
        CFG_TAPS = 16'd4; BIAS = 32'd0; OUT_READY = 1'b1;
        send_tap(32'd1, 4'h7, 1'b0);
        send_tap(32'd1, 4'h7, 1'b0);
        RESET_N = 1'b0;
        @(posedge CLK); #1;
        RESET_N = 1'b1;
        n_checks += 5;
        if (OUT_VALID !== 1'b0) begin n_fail++; $display("FAIL rst_mid_valid: got %b required 0", OUT_VALID); end
        if (OUT_DATA !== 32'h0) begin n_fail++; $display("FAIL rst_mid_data: got %h required 0", OUT_DATA); end
        if (OUT_USER !== 4'h0) begin n_fail++; $display("FAIL rst_mid_user: got %h required 0", OUT_USER); end
        if (OUT_LAST !== 1'b0) begin n_fail++; $display("FAIL rst_mid_last: got %b required 0", OUT_LAST); end
        if (ERR_LAST !== 1'b0) begin n_fail++; $display("FAIL rst_mid_err: got %b required 0", ERR_LAST); end
        for (int i = 0; i < 4; i++) send_tap(32'd1, 4'h0, 1'b0);
        n_checks += 2;
        if (OUT_VALID !== 1'b1) begin n_fail++; $display("FAIL rst_mid_result_valid: got %b required 1", OUT_VALID); end
        if (OUT_DATA !== 32'd4) begin n_fail++; $display("FAIL rst_mid_result: got %0d required 4", OUT_DATA); end
    endtask

    initial begin
        RESET_N = 1'b0; CFG_TAPS = 16'd1; BIAS = '0; IN_VALID = 1'b0; IN_DATA = '0;
        IN_USER = '0; IN_LAST = 1'b0; OUT_READY = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        RESET_N = 1'b1;
        #1;
        test_reset();
        test_basic_sum();
        test_saturate();
        test_taps_zero();
        test_back_to_back();
        test_last();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
